// File: rtl/y86_regfile_decode.sv
// y86_regfile_decode: Y86-64 decode stage with an integrated, resettable register file.
// Decodes icode/rA/rB into source IDs and reads operands into registered valA/valB.
// Two write ports (E, M) update the file on each rising edge. M wins on a
// same-register conflict, and same-cycle reads see the written value.
// Ports:
//   clk, rst                rising-edge clock, async active-high reset
//   in_valid, icode, rA, rB decode request and register specifiers from fetch
//   we_e, dst_e, val_e      write port E
//   we_m, dst_m, val_m      write port M (priority over E)
//   out_valid               srcA/srcB/valA/valB hold fresh results this cycle
//   srcA, srcB              registered decoded source IDs
//   valA, valB              registered operands
//   dbg_regs                flat view of the file, entry i at [i*XLEN +: XLEN]
module y86_regfile_decode #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREG   = 15,
   parameter logic [3:0]  RNONE  = 4'hF,
   parameter logic [3:0]  RSP_ID = 4'h4,
   localparam int unsigned IDW   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [IDW-1:0]       icode,
   input  logic [IDW-1:0]       rA,
   input  logic [IDW-1:0]       rB,
   input  logic                 we_e,
   input  logic [IDW-1:0]       dst_e,
   input  logic [XLEN-1:0]      val_e,
   input  logic                 we_m,
   input  logic [IDW-1:0]       dst_m,
   input  logic [XLEN-1:0]      val_m,
   output logic                 out_valid,
   output logic [IDW-1:0]       srcA,
   output logic [IDW-1:0]       srcB,
   output logic [XLEN-1:0]      valA,
   output logic [XLEN-1:0]      valB,
   output logic [NREG*XLEN-1:0] dbg_regs
);

   logic [XLEN-1:0] regs [NREG];
   logic [IDW-1:0]  dec_a_c;
   logic [IDW-1:0]  dec_b_c;
   logic [XLEN-1:0] rd_a_c;
   logic [XLEN-1:0] rd_b_c;
   logic            wr_e_c;
   logic            wr_m_c;

   // Writes to RNONE or IDs beyond the implemented file are dropped.
   assign wr_e_c = we_e && (32'(dst_e) < NREG);
   assign wr_m_c = we_m && (32'(dst_m) < NREG);

   // Source register decode.
   always_comb begin
      dec_a_c = RNONE;
      dec_b_c = RNONE;
      case (icode)
         4'h2: dec_a_c = rA;
         4'h4: begin dec_a_c = rA;     dec_b_c = rB;     end
         4'h5: dec_b_c = rB;
         4'h6: begin dec_a_c = rA;     dec_b_c = rB;     end
         4'h8: dec_b_c = RSP_ID;
         4'h9: begin dec_a_c = RSP_ID; dec_b_c = RSP_ID; end
         4'hA: begin dec_a_c = rA;     dec_b_c = RSP_ID; end
         4'hB: begin dec_a_c = RSP_ID; dec_b_c = RSP_ID; end
         default: ;
      endcase
   end

   // Operand read with write-before-read bypass; M is applied last so it wins.
   // Unmatched IDs (RNONE, out of range) fall through to zero.
   always_comb begin
      rd_a_c = '0;
      rd_b_c = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (dec_a_c == IDW'(i)) rd_a_c = regs[i];
         if (dec_b_c == IDW'(i)) rd_b_c = regs[i];
      end
      if (wr_e_c && (dst_e == dec_a_c)) rd_a_c = val_e;
      if (wr_e_c && (dst_e == dec_b_c)) rd_b_c = val_e;
      if (wr_m_c && (dst_m == dec_a_c)) rd_a_c = val_m;
      if (wr_m_c && (dst_m == dec_b_c)) rd_b_c = val_m;
   end

   // Register file storage; M takes the entry when both ports hit it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (wr_m_c && (dst_m == IDW'(i)))      regs[i] <= val_m;
            else if (wr_e_c && (dst_e == IDW'(i))) regs[i] <= val_e;
         end
      end
   end

   // Decode results; held while no request is presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         srcA      <= RNONE;
         srcB      <= RNONE;
         valA      <= '0;
         valB      <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            srcA <= dec_a_c;
            srcB <= dec_b_c;
            valA <= rd_a_c;
            valB <= rd_b_c;
         end
      end
   end

   // Flat debug view of the register flops.
   for (genvar g = 0; g < int'(NREG); g++) begin : g_dbg
      assign dbg_regs[g*XLEN +: XLEN] = regs[g];
   end

endmodule

// File: tb/tb_y86_regfile_decode.sv
// tb_y86_regfile_decode: self-checking bench for y86_regfile_decode (NREG=8).
// Directed vector table, reset corner sequences and a randomized phase, all
// checked against a file-level model: writes are applied first, then the
// request reads the updated file.
module tb_y86_regfile_decode;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 8;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 in_valid = 1'b0;
   logic [3:0]           icode = '0, rA = '0, rB = '0;
   logic                 we_e = 1'b0, we_m = 1'b0;
   logic [3:0]           dst_e = '0, dst_m = '0;
   logic [XLEN-1:0]      val_e = '0, val_m = '0;
   logic                 out_valid;
   logic [3:0]           srcA, srcB;
   logic [XLEN-1:0]      valA, valB;
   logic [NREG*XLEN-1:0] dbg_regs;

   int checks = 0;
   int errors = 0;

   y86_regfile_decode #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .icode(icode), .rA(rA), .rB(rB),
      .we_e(we_e), .dst_e(dst_e), .val_e(val_e),
      .we_m(we_m), .dst_m(dst_m), .val_m(val_m),
      .out_valid(out_valid), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .dbg_regs(dbg_regs)
   );

   always #5 clk = ~clk;

   // Model state
   logic [XLEN-1:0] m_regs [16];
   logic            e_ov;
   logic [3:0]      e_srca, e_srcb;
   logic [XLEN-1:0] e_vala, e_valb;

   typedef struct {
      logic       iv;
      logic [3:0] ic, ra, rb;
      logic       wee;
      logic [3:0] de;
      logic [63:0] ve;
      logic       wem;
      logic [3:0] dm;
      logic [63:0] vm;
      logic       ov;
      logic [3:0] sa, sb;
      logic [63:0] va, vb;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic iv, input logic [3:0] ic, ra, rb,
                               input logic wee, input logic [3:0] de, input logic [63:0] ve,
                               input logic wem, input logic [3:0] dm, input logic [63:0] vm,
                               input logic ov, input logic [3:0] sa, sb,
                               input logic [63:0] va, vb);
      vec_t v;
      v.iv = iv; v.ic = ic; v.ra = ra; v.rb = rb;
      v.wee = wee; v.de = de; v.ve = ve; v.wem = wem; v.dm = dm; v.vm = vm;
      v.ov = ov; v.sa = sa; v.sb = sb; v.va = va; v.vb = vb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] m_read(input logic [3:0] id);
      return (32'(id) < NREG) ? m_regs[id] : 64'd0;
   endfunction

   // Source IDs read by each instruction class.
   task automatic m_decode(input logic [3:0] ic, ra, rb, output logic [3:0] a, b);
      a = 4'hF; b = 4'hF;
      case (ic)
         4'h2: a = ra;
         4'h4, 4'h6: begin a = ra; b = rb; end
         4'h5: b = rb;
         4'h8: b = 4'd4;
         4'h9, 4'hB: begin a = 4'd4; b = 4'd4; end
         4'hA: begin a = ra; b = 4'd4; end
         default: ;
      endcase
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      e_ov = 1'b0; e_srca = 4'hF; e_srcb = 4'hF; e_vala = '0; e_valb = '0;
   endtask

   // Model of one rising edge given the currently driven inputs.
   task automatic m_edge();
      logic [3:0] a, b;
      if (we_e && 32'(dst_e) < NREG) m_regs[dst_e] = val_e;
      if (we_m && 32'(dst_m) < NREG) m_regs[dst_m] = val_m;
      e_ov = in_valid;
      if (in_valid) begin
         m_decode(icode, rA, rB, a, b);
         e_srca = a; e_srcb = b;
         e_vala = m_read(a); e_valb = m_read(b);
      end
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
      chk({tag, ".srcA"}, 64'(srcA), 64'(e_srca));
      chk({tag, ".srcB"}, 64'(srcB), 64'(e_srcb));
      chk({tag, ".valA"}, valA, e_vala);
      chk({tag, ".valB"}, valB, e_valb);
      for (int i = 0; i < int'(NREG); i++)
         chk($sformatf("%s.dbg%0d", tag, i), dbg_regs[i*XLEN +: XLEN], m_regs[i]);
   endtask

   // Apply one cycle; inputs are already driven (at posedge+1).
   task automatic step(input string tag);
      m_edge();
      @(posedge clk); #1;
      compare_model(tag);
   endtask

   task automatic idle_inputs();
      in_valid = 0; icode = 0; rA = 0; rB = 0;
      we_e = 0; dst_e = 0; val_e = 0; we_m = 0; dst_m = 0; val_m = 0;
   endtask

   // Mid-cycle async reset with writes presented, then synchronous release.
   task automatic reset_seq(input string tag);
      #2;
      rst = 1;
      we_e = 1; dst_e = 4'd1; val_e = 64'h55;
      we_m = 1; dst_m = 4'd2; val_m = 64'h66;
      #1;
      chk({tag, ".rst_ov"}, 64'(out_valid), 64'd0);
      chk({tag, ".rst_srcA"}, 64'(srcA), 64'hF);
      chk({tag, ".rst_srcB"}, 64'(srcB), 64'hF);
      chk({tag, ".rst_valA"}, valA, 64'd0);
      chk({tag, ".rst_valB"}, valB, 64'd0);
      for (int i = 0; i < int'(NREG); i++)
         chk($sformatf("%s.rst_dbg%0d", tag, i), dbg_regs[i*XLEN +: XLEN], 64'd0);
      @(posedge clk); #1;
      chk({tag, ".rst_wr_lost1"}, dbg_regs[1*XLEN +: XLEN], 64'd0);
      chk({tag, ".rst_wr_lost2"}, dbg_regs[2*XLEN +: XLEN], 64'd0);
      rst = 0;
      idle_inputs();
      m_reset();
   endtask

   initial begin
      m_reset();
      @(posedge clk); #1;
      reset_seq("init");
      step("post_init");

      //       iv ic    ra    rb    wee de    ve       wem dm    vm       ov sa    sb    va       vb
      tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 4'h2, 64'd333, 1, 4'h3, 64'd444, 0, 4'hF, 4'hF, 64'd0, 64'd0));
      tbl.push_back(mk(1, 4'h6, 4'h2, 4'h3, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'h2, 4'h3, 64'd333, 64'd444));
      tbl.push_back(mk(0, 4'h6, 4'h0, 4'h0, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   0, 4'h2, 4'h3, 64'd333, 64'd444));
      tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 4'h4, 64'd555, 0, 4'h0, 64'd0,   0, 4'h2, 4'h3, 64'd333, 64'd444));
      tbl.push_back(mk(1, 4'hA, 4'h0, 4'h0, 1, 4'h0, 64'd111, 1, 4'h4, 64'd547, 1, 4'h0, 4'h4, 64'd111, 64'd547));
      tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 4'h4, 64'd100, 1, 4'h4, 64'd200, 0, 4'h0, 4'h4, 64'd111, 64'd547));
      tbl.push_back(mk(1, 4'h9, 4'h0, 4'h0, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'h4, 4'h4, 64'd200, 64'd200));
      tbl.push_back(mk(0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 64'hDEAD,1, 4'h9, 64'hDEAD,0, 4'h4, 4'h4, 64'd200, 64'd200));
      tbl.push_back(mk(1, 4'h5, 4'h1, 4'h9, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'hF, 4'h9, 64'd0, 64'd0));
      tbl.push_back(mk(1, 4'h3, 4'h2, 4'h3, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'hF, 4'hF, 64'd0, 64'd0));
      tbl.push_back(mk(1, 4'h2, 4'h3, 4'h2, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'h3, 4'hF, 64'd444, 64'd0));
      tbl.push_back(mk(1, 4'hB, 4'h1, 4'h1, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'h4, 4'h4, 64'd200, 64'd200));
      tbl.push_back(mk(1, 4'h8, 4'h1, 4'h1, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'hF, 4'h4, 64'd0, 64'd200));
      tbl.push_back(mk(1, 4'h0, 4'h1, 4'h2, 0, 4'h0, 64'd0,   0, 4'h0, 64'd0,   1, 4'hF, 4'hF, 64'd0, 64'd0));
      tbl.push_back(mk(1, 4'h5, 4'h0, 4'h2, 1, 4'h2, 64'd7,   1, 4'h2, 64'd9,   1, 4'hF, 4'h2, 64'd0, 64'd9));
      tbl.push_back(mk(1, 4'h4, 4'h7, 4'h5, 1, 4'h7, 64'd77,  0, 4'h0, 64'd0,   1, 4'h7, 4'h5, 64'd77, 64'd0));
      tbl.push_back(mk(1, 4'h5, 4'h0, 4'h8, 1, 4'h8, 64'd1,   1, 4'h8, 64'd2,   1, 4'hF, 4'h8, 64'd0, 64'd0));

      foreach (tbl[k]) begin
         in_valid = tbl[k].iv; icode = tbl[k].ic; rA = tbl[k].ra; rB = tbl[k].rb;
         we_e = tbl[k].wee; dst_e = tbl[k].de; val_e = tbl[k].ve;
         we_m = tbl[k].wem; dst_m = tbl[k].dm; val_m = tbl[k].vm;
         step($sformatf("vec%0d", k));
         chk($sformatf("vec%0d.tbl_ov", k), 64'(out_valid), 64'(tbl[k].ov));
         chk($sformatf("vec%0d.tbl_srcA", k), 64'(srcA), 64'(tbl[k].sa));
         chk($sformatf("vec%0d.tbl_srcB", k), 64'(srcB), 64'(tbl[k].sb));
         chk($sformatf("vec%0d.tbl_valA", k), valA, tbl[k].va);
         chk($sformatf("vec%0d.tbl_valB", k), valB, tbl[k].vb);
      end
      chk("conflict_r4", dbg_regs[4*XLEN +: XLEN], 64'd200);

      // Reset while an rmmovq result is being presented.
      idle_inputs();
      in_valid = 1; icode = 4'h4; rA = 4'h2; rB = 4'h3;
      step("midop_req");
      chk("midop_ov_before", 64'(out_valid), 64'd1);
      reset_seq("midop");
      step("midop_after");
      in_valid = 1; icode = 4'h6; rA = 4'h2; rB = 4'h3;
      step("midop_read");
      chk("midop_read_valA", valA, 64'd0);
      chk("midop_read_valB", valB, 64'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         in_valid = 1'($urandom_range(0, 3) != 0);
         icode = 4'($urandom_range(0, 11));
         rA = 4'($urandom_range(0, 15));
         rB = 4'($urandom_range(0, 15));
         we_e = 1'($urandom_range(0, 1));
         we_m = 1'($urandom_range(0, 1));
         dst_e = 4'($urandom_range(0, 15));
         dst_m = ($urandom_range(0, 3) == 0) ? dst_e : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) dst_e = rA;
         val_e = {$urandom, $urandom};
         val_m = {$urandom, $urandom};
         step($sformatf("rnd%0d", n));
      end

      reset_seq("final");
      step("final_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
